tdm_demux_1x4: RTL and testbench
================================

# tdm_demux_1x4

Four-slot time-division demultiplexer: the receive-side counterpart of the 4:1 mux path. It accepts one sample per enabled clock on a shared data line, aligned by a frame-sync strobe on slot 0. Each sample is steered into one of four channel registers, and a complete frame is presented on four parallel outputs with a one-cycle valid strobe. It sits downstream of the 4:1 selector chain, whose select lines are driven by a 2-bit slot counter.

## Interface
- WIDTH, 1, bits per sample/channel
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- en  input  1  sample-accept qualifier; din/fsync are ignored when low
- din  input  WIDTH  serialized sample
- fsync  input  1  marks the slot-0 sample; sampled only when en=1
- y0, y1, y2, y3  output  WIDTH each  registered channel outputs, updated once per complete frame
- frame_valid  output  1  one-cycle pulse: y0..y3 updated this cycle
- slot  output  2  next slot index expected (0..3)
- err  output  1  sticky sync-error flag (see Configuration)
- err_clr  input  1  clears err (ignored without the macro)

## Operation
- States: IDLE (hunting for sync), RUN (assembling a frame).
- An accept is a rising edge with en=1. On a cycle with en=0 nothing changes except frame_valid, which drops to 0.
- IDLE:
  - Accept with fsync=1: din goes to shadow[0], slot becomes 1, state goes to RUN.
  - Accept with fsync=0: the sample is discarded and the block stays in IDLE.
- RUN, accept at slot k, k=1..3, fsync=0: din goes to shadow[k] and slot becomes k+1 (mod 4).
- RUN, accept at slot 3: y0..y2 take shadow[0..2] and y3 takes din directly, with no extra cycle. frame_valid=1 and slot wraps to 0.
- RUN, accept at slot 0:
  - fsync=1: normal frame start, handled as in IDLE.
  - fsync=0: lost sync. The sample is discarded, state goes to IDLE and slot goes to 0.
- RUN, accept at slot 1..3 with fsync=1: early sync. The partial frame is dropped and y* is untouched. The sample is taken as the new slot 0: din goes to shadow[0] and slot becomes 1.
- y0..y3 hold their last values between frames and are never partially updated.
- Shadow registers are internal only. Their contents after a dropped frame are don't-care.

## Timing
- Reset values: state=IDLE, slot=0, y0..y3=0, frame_valid=0, err=0, shadow=0.
- Latency: y*/frame_valid change at the same edge that accepts the slot-3 sample. They are visible the cycle after din(slot 3) is presented.
- Minimum frame period is 4 cycles. Back-to-back frames give a frame_valid pulse every 4th cycle with no bubbles.
- en may drop at any slot. The frame resumes at the same slot with no loss.
- rst asserted mid-frame: all state returns to reset values at that edge, and the partial frame is discarded.
- rst has priority over en, fsync and err_clr.

## Configuration
- Macro: TDM_DEMUX_ERR_EN.
- Defined:
  - err sets to 1 on lost sync (RUN, slot 0, fsync=0) and on early sync (RUN, slot 1..3, fsync=1).
  - err stays set until err_clr=1 or rst.
  - If err_clr and a new error occur in the same cycle, set wins: err stays 1.
- Undefined: err is tied to 0 and err_clr is unused. Resync behaviour is identical in both configurations.

## Structure
- Shared package holds:
  - NUM_SLOTS=4 and SLOT_W=2.
  - The state enum {IDLE, RUN}.
- Natural sub-module: tdm_slot_ctr. It is a 2-bit counter with enable, synchronous load-to-1 on sync, clear, and a wrap flag; it drives slot.
- Channel steering (demux decode of slot into four load enables) stays inline in the top module.

## Test plan
- Aligned frame, WIDTH=4:
  - Stimulus: en=1; din=A,B,C,D over 4 cycles; fsync=1 on A only.
  - Required: y0..y3=A,B,C,D and frame_valid=1 for exactly one cycle after D; slot sequence 1,2,3,0.
- Stall:
  - Stimulus: as above, but en=0 for 3 cycles between B and C.
  - Required: same outputs; frame_valid delayed 3 cycles; slot holds at 2 during the stall.
- Missing sync:
  - Stimulus: after one good frame, next accept has fsync=0 with din=5; then a new fsync frame 1,2,3,4.
  - Required: din=5 discarded; IDLE; y* unchanged until frame 1,2,3,4 completes; err=1 with macro, 0 without.
- Early sync:
  - Stimulus: fsync on slot-2 accept (din=9), followed by 8,7,6.
  - Required: frame_valid only after 6, with y=9,8,7,6; err=1 with macro.
- Reset mid-frame:
  - Stimulus: rst=1 after slot-1 accept.
  - Required: y*=0, slot=0, frame_valid=0, err=0 next cycle; an accept with fsync=0 afterwards is ignored.
- err_clr collision (macro on):
  - Stimulus: err_clr=1 in the same cycle as a lost-sync accept.
  - Required: err stays 1; err_clr alone in the following cycle clears it to 0.

Source files
------------

// File: rtl/tdm_demux_1x4_pkg.sv
// Shared constants and FSM state encoding for the 4-slot TDM demultiplexer.
package tdm_demux_1x4_pkg;

    localparam int unsigned NUM_SLOTS = 4;
    localparam int unsigned SLOT_W    = 2;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/tdm_demux_1x4_if.sv
// Serial-in / frame-out bus of the TDM demultiplexer; master drives samples, slave is the demux.
interface tdm_demux_1x4_if
    import tdm_demux_1x4_pkg::*;
#(
    parameter int unsigned WIDTH = 1
);

    logic              en;
    logic [WIDTH-1:0]  din;
    logic              fsync;
    logic              err_clr;
    logic [WIDTH-1:0]  y0;
    logic [WIDTH-1:0]  y1;
    logic [WIDTH-1:0]  y2;
    logic [WIDTH-1:0]  y3;
    logic              frame_valid;
    logic [SLOT_W-1:0] slot;
    logic              err;

    modport master (
        output en, din, fsync, err_clr,
        input  y0, y1, y2, y3, frame_valid, slot, err
    );

    modport slave (
        input  en, din, fsync, err_clr,
        output y0, y1, y2, y3, frame_valid, slot, err
    );

endinterface

// File: rtl/tdm_slot_ctr.sv
// 2-bit slot counter: clear, load-to-1 on sync, increment; wrap flag marks the slot-3 advance.
module tdm_slot_ctr
    import tdm_demux_1x4_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_inc,
    input  logic              i_load1,
    input  logic              i_clr,
    output logic [SLOT_W-1:0] o_slot,
    output logic              o_wrap_c
);

    logic [SLOT_W-1:0] r_slot;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_slot <= '0;
        end else if (i_clr) begin
            r_slot <= '0;
        end else if (i_load1) begin
            r_slot <= SLOT_W'(1);
        end else if (i_inc) begin
            r_slot <= r_slot + SLOT_W'(1);
        end
    end

    assign o_slot   = r_slot;
    assign o_wrap_c = i_inc && (r_slot == SLOT_W'(NUM_SLOTS - 1));

endmodule

// File: rtl/tdm_demux_1x4.sv
// Four-slot TDM demultiplexer: fsync-aligned samples gathered into shadow regs, frame published on slot 3.
// Optional sticky sync-error flag enabled by defining TDM_DEMUX_ERR_EN.
module tdm_demux_1x4
    import tdm_demux_1x4_pkg::*;
#(
    parameter int unsigned WIDTH = 1
) (
    input logic             clk,
    input logic             rst,
    tdm_demux_1x4_if.slave  bus
);

    localparam logic [0:0] ST_IDLE = IDLE;
    localparam logic [0:0] ST_RUN  = RUN;

    logic [0:0]        r_state;
    logic [0:0]        w_state_nxt;
    logic [WIDTH-1:0]  r_sh0;
    logic [WIDTH-1:0]  r_sh1;
    logic [WIDTH-1:0]  r_sh2;
    logic [WIDTH-1:0]  r_y0;
    logic [WIDTH-1:0]  r_y1;
    logic [WIDTH-1:0]  r_y2;
    logic [WIDTH-1:0]  r_y3;
    logic              r_frame_valid;
    logic [2:0]        w_ld_sh;
    logic              w_inc;
    logic              w_load1;
    logic              w_clr;
    logic              w_err_set;
    logic              w_frame_done;
    logic [SLOT_W-1:0] w_slot;

    tdm_slot_ctr u_slot_ctr (
        .clk      (clk),
        .rst      (rst),
        .i_inc    (w_inc),
        .i_load1  (w_load1),
        .i_clr    (w_clr),
        .o_slot   (w_slot),
        .o_wrap_c (w_frame_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, counter control and channel steering; an fsync accept always restarts at slot 0.
    always_comb begin
        w_state_nxt = r_state;
        w_inc       = 1'b0;
        w_load1     = 1'b0;
        w_clr       = 1'b0;
        w_ld_sh     = 3'b000;
        w_err_set   = 1'b0;
        if (bus.en) begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.fsync) begin
                        w_load1     = 1'b1;
                        w_ld_sh[0]  = 1'b1;
                        w_state_nxt = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_slot == SLOT_W'(0)) begin
                        if (bus.fsync) begin
                            w_load1    = 1'b1;
                            w_ld_sh[0] = 1'b1;
                        end else begin
                            w_clr       = 1'b1;
                            w_err_set   = 1'b1;
                            w_state_nxt = ST_IDLE;
                        end
                    end else if (bus.fsync) begin
                        w_load1    = 1'b1;
                        w_ld_sh[0] = 1'b1;
                        w_err_set  = 1'b1;
                    end else begin
                        w_inc = 1'b1;
                        case (w_slot)
                            SLOT_W'(1): w_ld_sh[1] = 1'b1;
                            SLOT_W'(2): w_ld_sh[2] = 1'b1;
                            default:    ;
                        endcase
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sh0 <= '0;
            r_sh1 <= '0;
            r_sh2 <= '0;
        end else begin
            if (w_ld_sh[0]) r_sh0 <= bus.din;
            if (w_ld_sh[1]) r_sh1 <= bus.din;
            if (w_ld_sh[2]) r_sh2 <= bus.din;
        end
    end

    // Slot 3 bypasses its shadow so the frame lands on the same edge as its last sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_y0          <= '0;
            r_y1          <= '0;
            r_y2          <= '0;
            r_y3          <= '0;
            r_frame_valid <= 1'b0;
        end else begin
            r_frame_valid <= w_frame_done;
            if (w_frame_done) begin
                r_y0 <= r_sh0;
                r_y1 <= r_sh1;
                r_y2 <= r_sh2;
                r_y3 <= bus.din;
            end
        end
    end

`ifdef TDM_DEMUX_ERR_EN
    logic r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_err_set) begin
            r_err <= 1'b1;
        end else if (bus.err_clr) begin
            r_err <= 1'b0;
        end
    end

    assign bus.err = r_err;
`else
    logic w_unused_err;
    assign w_unused_err = ^{bus.err_clr, w_err_set};
    assign bus.err      = 1'b0;
`endif

    assign bus.y0          = r_y0;
    assign bus.y1          = r_y1;
    assign bus.y2          = r_y2;
    assign bus.y3          = r_y3;
    assign bus.frame_valid = r_frame_valid;
    assign bus.slot        = w_slot;

endmodule

// File: tb/tb_tdm_demux_1x4.sv
// Directed self-checking bench for tdm_demux_1x4 at WIDTH=4; honours TDM_DEMUX_ERR_EN for err expectations.
module tb_tdm_demux_1x4;

`ifdef TDM_DEMUX_ERR_EN
    localparam logic E_ERR = 1'b1;
`else
    localparam logic E_ERR = 1'b0;
`endif

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    tdm_demux_1x4_if #(.WIDTH(4)) bus ();

    tdm_demux_1x4 #(.WIDTH(4)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input logic en, input logic fs, input logic [3:0] d, input logic clr);
        bus.en      = en;
        bus.fsync   = fs;
        bus.din     = d;
        bus.err_clr = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(1'b0, 1'b0, 4'h0, 1'b0);
        step(1'b0, 1'b0, 4'h0, 1'b0);
        rst = 1'b0;
        checks++;
        if ({bus.y0, bus.y1, bus.y2, bus.y3} !== 16'h0000) begin
            errors++; $display("FAIL reset_y got %h exp 0000", {bus.y0, bus.y1, bus.y2, bus.y3});
        end
        checks++;
        if ({bus.frame_valid, bus.slot, bus.err} !== 4'b0000) begin
            errors++; $display("FAIL reset_fv_slot_err got %b exp 0000", {bus.frame_valid, bus.slot, bus.err});
        end
    endtask

    task automatic test_aligned();
        logic [3:0]  din_v [4];
        logic [1:0]  slot_e [4];
        din_v  = '{4'hA, 4'hB, 4'hC, 4'hD};
        slot_e = '{2'd1, 2'd2, 2'd3, 2'd0};
        for (int i = 0; i < 4; i++) begin
            step(1'b1, (i == 0), din_v[i], 1'b0);
            checks++;
            if (bus.slot !== slot_e[i] || bus.frame_valid !== (i == 3)) begin
                errors++; $display("FAIL aligned_slot_fv[%0d] got slot %0d fv %b exp slot %0d fv %b",
                                   i, bus.slot, bus.frame_valid, slot_e[i], (i == 3));
            end
        end
        checks++;
        if ({bus.y0, bus.y1, bus.y2, bus.y3} !== 16'hABCD) begin
            errors++; $display("FAIL aligned_y got %h exp ABCD", {bus.y0, bus.y1, bus.y2, bus.y3});
        end
        step(1'b0, 1'b0, 4'h0, 1'b0);
        checks++;
        if (bus.frame_valid !== 1'b0 || {bus.y0, bus.y1, bus.y2, bus.y3} !== 16'hABCD) begin
            errors++; $display("FAIL aligned_pulse_width got fv %b y %h exp fv 0 y ABCD",
                               bus.frame_valid, {bus.y0, bus.y1, bus.y2, bus.y3});
        end
    endtask

    task automatic test_stall();
        step(1'b1, 1'b1, 4'hC, 1'b0);
        step(1'b1, 1'b0, 4'hD, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 4'h9, 1'b0);
            checks++;
            if (bus.slot !== 2'd2 || bus.frame_valid !== 1'b0) begin
                errors++; $display("FAIL stall_hold[%0d] got slot %0d fv %b exp slot 2 fv 0",
                                   i, bus.slot, bus.frame_valid);
            end
        end
        step(1'b1, 1'b0, 4'hE, 1'b0);
        checks++;
        if (bus.slot !== 2'd3 || bus.frame_valid !== 1'b0) begin
            errors++; $display("FAIL stall_resume got slot %0d fv %b exp slot 3 fv 0", bus.slot, bus.frame_valid);
        end
        step(1'b1, 1'b0, 4'hF, 1'b0);
        checks++;
        if (bus.frame_valid !== 1'b1 || {bus.y0, bus.y1, bus.y2, bus.y3} !== 16'hCDEF) begin
            errors++; $display("FAIL stall_frame got fv %b y %h exp fv 1 y CDEF",
                               bus.frame_valid, {bus.y0, bus.y1, bus.y2, bus.y3});
        end
    endtask

    task automatic test_missing_sync();
        step(1'b1, 1'b0, 4'h5, 1'b0);
        checks++;
        if (bus.slot !== 2'd0 || bus.frame_valid !== 1'b0 || bus.err !== E_ERR) begin
            errors++; $display("FAIL lost_sync got slot %0d fv %b err %b exp slot 0 fv 0 err %b",
                               bus.slot, bus.frame_valid, bus.err, E_ERR);
        end
        step(1'b1, 1'b0, 4'h7, 1'b0);
        checks++;
        if (bus.slot !== 2'd0 || {bus.y0, bus.y1, bus.y2, bus.y3} !== 16'hCDEF) begin
            errors++; $display("FAIL idle_discard got slot %0d y %h exp slot 0 y CDEF",
                               bus.slot, {bus.y0, bus.y1, bus.y2, bus.y3});
        end
        step(1'b1, 1'b1, 4'h1, 1'b0);
        step(1'b1, 1'b0, 4'h2, 1'b0);
        step(1'b1, 1'b0, 4'h3, 1'b0);
        checks++;
        if (bus.slot !== 2'd3 || {bus.y0, bus.y1, bus.y2, bus.y3} !== 16'hCDEF) begin
            errors++; $display("FAIL resync_partial got slot %0d y %h exp slot 3 y CDEF",
                               bus.slot, {bus.y0, bus.y1, bus.y2, bus.y3});
        end
        step(1'b1, 1'b0, 4'h4, 1'b0);
        checks++;
        if (bus.frame_valid !== 1'b1 || {bus.y0, bus.y1, bus.y2, bus.y3} !== 16'h1234 || bus.err !== E_ERR) begin
            errors++; $display("FAIL resync_frame got fv %b y %h err %b exp fv 1 y 1234 err %b",
                               bus.frame_valid, {bus.y0, bus.y1, bus.y2, bus.y3}, bus.err, E_ERR);
        end
    endtask

    task automatic test_early_sync();
        step(1'b0, 1'b0, 4'h0, 1'b1);
        checks++;
        if (bus.err !== 1'b0) begin
            errors++; $display("FAIL err_clear got %b exp 0", bus.err);
        end
        step(1'b1, 1'b1, 4'hA, 1'b0);
        step(1'b1, 1'b0, 4'hB, 1'b0);
        step(1'b1, 1'b1, 4'h9, 1'b0);
        checks++;
        if (bus.slot !== 2'd1 || bus.frame_valid !== 1'b0 || bus.err !== E_ERR ||
            {bus.y0, bus.y1, bus.y2, bus.y3} !== 16'h1234) begin
            errors++; $display("FAIL early_sync got slot %0d fv %b err %b y %h exp slot 1 fv 0 err %b y 1234",
                               bus.slot, bus.frame_valid, bus.err, {bus.y0, bus.y1, bus.y2, bus.y3}, E_ERR);
        end
        step(1'b1, 1'b0, 4'h8, 1'b0);
        step(1'b1, 1'b0, 4'h7, 1'b0);
        step(1'b1, 1'b0, 4'h6, 1'b0);
        checks++;
        if (bus.frame_valid !== 1'b1 || {bus.y0, bus.y1, bus.y2, bus.y3} !== 16'h9876 || bus.slot !== 2'd0) begin
            errors++; $display("FAIL early_frame got fv %b y %h slot %0d exp fv 1 y 9876 slot 0",
                               bus.frame_valid, {bus.y0, bus.y1, bus.y2, bus.y3}, bus.slot);
        end
    endtask

    task automatic test_reset_mid();
        step(1'b1, 1'b1, 4'h3, 1'b0);
        rst = 1'b1;
        step(1'b1, 1'b1, 4'h4, 1'b0);
        rst = 1'b0;
        checks++;
        if ({bus.y0, bus.y1, bus.y2, bus.y3} !== 16'h0000 || {bus.frame_valid, bus.slot, bus.err} !== 4'b0000) begin
            errors++; $display("FAIL rst_mid got y %h fv/slot/err %b exp y 0000 fv/slot/err 0000",
                               {bus.y0, bus.y1, bus.y2, bus.y3}, {bus.frame_valid, bus.slot, bus.err});
        end
        step(1'b1, 1'b0, 4'h5, 1'b0);
        checks++;
        if (bus.slot !== 2'd0 || bus.frame_valid !== 1'b0 || {bus.y0, bus.y1, bus.y2, bus.y3} !== 16'h0000) begin
            errors++; $display("FAIL rst_then_nosync got slot %0d fv %b y %h exp slot 0 fv 0 y 0000",
                               bus.slot, bus.frame_valid, {bus.y0, bus.y1, bus.y2, bus.y3});
        end
    endtask

    task automatic test_err_clr_collision();
        step(1'b1, 1'b1, 4'h1, 1'b0);
        step(1'b1, 1'b0, 4'h2, 1'b0);
        step(1'b1, 1'b0, 4'h3, 1'b0);
        step(1'b1, 1'b0, 4'h4, 1'b0);
        step(1'b1, 1'b0, 4'h5, 1'b1);
        checks++;
        if (bus.err !== E_ERR || bus.slot !== 2'd0) begin
            errors++; $display("FAIL clr_collision got err %b slot %0d exp err %b slot 0", bus.err, bus.slot, E_ERR);
        end
        step(1'b0, 1'b0, 4'h0, 1'b1);
        checks++;
        if (bus.err !== 1'b0) begin
            errors++; $display("FAIL clr_alone got %b exp 0", bus.err);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            step(1'b1, (i % 4 == 0), 4'(i + 3), 1'b0);
            checks++;
            if (bus.frame_valid !== (i % 4 == 3)) begin
                errors++; $display("FAIL b2b_fv[%0d] got %b exp %b", i, bus.frame_valid, (i % 4 == 3));
            end
        end
        checks++;
        if ({bus.y0, bus.y1, bus.y2, bus.y3} !== 16'h789A) begin
            errors++; $display("FAIL b2b_y got %h exp 789A", {bus.y0, bus.y1, bus.y2, bus.y3});
        end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        rst         = 1'b1;
        bus.en      = 1'b0;
        bus.fsync   = 1'b0;
        bus.din     = 4'h0;
        bus.err_clr = 1'b0;
        test_reset();
        test_aligned();
        test_stall();
        test_missing_sync();
        test_early_sync();
        test_reset_mid();
        test_err_clr_collision();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
